// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per
// cycle, with a start/busy/done handshake and HI/LO result registers.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [CW-1:0]      count_reg;
  logic               is_div_reg;
  logic               neg_q_reg;
  logic               neg_r_reg;
  logic               div_zero_reg;
  logic [WIDTH-1:0]   operand_reg;
  logic [WIDTH-1:0]   raw_a_reg;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic [WIDTH-1:0]   hi_next, lo_next;
  logic               done_reg;
  logic               last_iter;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_fits;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quo, rem;

  assign last_iter = (count_reg == CW'(WIDTH - 1));

  // Operand magnitudes; only the signed ops (op[0]=1) look at the sign bits.
  always_comb begin
    a_neg = op[0] & a[WIDTH-1];
    b_neg = op[0] & b[WIDTH-1];
    mag_a = a_neg ? -a : a;
    mag_b = b_neg ? -b : b;
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_iter) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One iteration. Multiply keeps {partial product, remaining multiplier bits};
  // divide keeps {remainder, dividend bits shifting into quotient bits}.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, operand_reg} : '0);
    div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, operand_reg};
    div_fits  = ~div_diff[WIDTH];
    if (is_div_reg)
      acc_next = {(div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                  acc_reg[WIDTH-2:0], div_fits};
    else
      acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
  end

  // Sign correction; overflow (most negative / -1) falls out of the magnitude path.
  always_comb begin
    product = neg_q_reg ? -acc_reg : acc_reg;
    quo     = acc_reg[WIDTH-1:0];
    rem     = acc_reg[2*WIDTH-1:WIDTH];
    if (div_zero_reg) begin
      hi_next = raw_a_reg;
      lo_next = '1;
    end else if (is_div_reg) begin
      hi_next = neg_r_reg ? -rem : rem;
      lo_next = neg_q_reg ? -quo : quo;
    end else begin
      hi_next = product[2*WIDTH-1:WIDTH];
      lo_next = product[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg    <= '0;
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      operand_reg  <= '0;
      raw_a_reg    <= '0;
      acc_reg      <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            is_div_reg   <= op[1];
            neg_q_reg    <= a_neg ^ b_neg;
            neg_r_reg    <= a_neg;
            div_zero_reg <= op[1] & (b == '0);
            operand_reg  <= op[1] ? mag_b : mag_a;
            raw_a_reg    <= a;
            acc_reg      <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
            count_reg    <= '0;
          end
        end
        RUN: begin
          acc_reg   <= acc_next;
          count_reg <= last_iter ? '0 : count_reg + CW'(1);
        end
        FINISH: begin
          hi_reg   <= hi_next;
          lo_reg   <= lo_next;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // busy covers the done cycle too, so the controller sees it drop only after results land.
  assign busy = (state_reg != IDLE) || done_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule
